// File: rtl/constants_pkg.sv
// Shared constants and types for the pipeline register controller.
package constants_pkg;

    localparam int unsigned NUM_STAGES_DEF = 5;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned CNT_W_DEF      = 32;

    localparam int unsigned STG_DEC = 0;
    localparam int unsigned STG_RR  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef enum logic [1:0] {
        SelLoad,
        SelBubble,
        SelHold,
        SelKill
    } slot_sel_e;

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline register with a valid bit; kill and bubble clear only the valid bit.
module pipe_reg_slot
    import constants_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  slot_sel_e         sel,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic [DATA_W-1:0] data_q,
    output logic              valid_q
);

    logic [DATA_W-1:0] data_d;
    logic              valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        unique case (sel)
            SelLoad: begin
                data_d  = load_data;
                valid_d = load_valid;
            end
            SelHold:   valid_d = valid_q;
            SelBubble: valid_d = 1'b0;
            SelKill:   valid_d = 1'b0;
            default:   valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pipeline_regs_ctrl.sv
// Pipeline register bank with backward stall propagation, flush kill, bubble
// insertion and saturating performance counters.
module pipeline_regs_ctrl
    import constants_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic [(NUM_STAGES-1)*DATA_W-1:0] stage_d,
    input  logic [NUM_STAGES-1:0]            stall_req,
    input  logic [NUM_STAGES-1:0]            flush_req,
    output logic [NUM_STAGES*DATA_W-1:0]     stage_q,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [CNT_W-1:0]                 stall_cycles,
    output logic [CNT_W-1:0]                 bubble_cnt,
    output logic [CNT_W-1:0]                 flush_cnt
);

    logic [NUM_STAGES-1:0] hold, hold_prev, valid_prev, younger, kill;
    slot_sel_e             sel [NUM_STAGES];
    logic                  flush_any, bubble_hit;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    // younger[i]: some older stage (index > i) redirects, so reg i is always discarded
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_chain
        assign hold[g] = |stall_req[NUM_STAGES-1:g];
        if (g == NUM_STAGES - 1) begin : g_last
            assign younger[g] = 1'b0;
        end else begin : g_inner
            assign younger[g] = |flush_req[NUM_STAGES-1:g+1];
        end
    end

    assign kill       = younger | (flush_req & ~hold);
    assign hold_prev  = {hold[NUM_STAGES-2:0], 1'b0};
    assign valid_prev = {stage_valid[NUM_STAGES-2:0], 1'b0};
    assign flush_any  = |flush_req;
    assign in_ready   = ~hold[0] & ~flush_any;

    always_comb begin
        bubble_hit = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            sel[i] = SelLoad;
            if (kill[i]) begin
                sel[i] = SelKill;
            end else if (hold[i]) begin
                sel[i] = SelHold;
            end else if (hold_prev[i]) begin
                sel[i]     = SelBubble;
                bubble_hit = bubble_hit | valid_prev[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
        logic [DATA_W-1:0] ld_data;
        logic              ld_valid;

        if (g == 0) begin : g_head
            assign ld_data  = in_data;
            assign ld_valid = in_valid;
        end else begin : g_body
            assign ld_data  = stage_d[(g-1)*DATA_W +: DATA_W];
            assign ld_valid = stage_valid[g-1];
        end

        pipe_reg_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .sel       (sel[g]),
            .load_data (ld_data),
            .load_valid(ld_valid),
            .data_q    (stage_q[g*DATA_W +: DATA_W]),
            .valid_q   (stage_valid[g])
        );
    end

    // Counters saturate at all-ones
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_cnt_d   = bubble_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (hold[0] && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (bubble_hit && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        if (flush_any && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
            flush_cnt_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_cnt_q   <= bubble_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
